alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational ALU between two requesters: the issue stage (port 0) and the multi-cycle helper unit (port 1). The block uses round-robin arbitration and a valid/ready handshake on each request port. It registers the ALU result into a one-entry output stage with backpressure. It sits between the requesters and the ALU instance and is the only block that drives the ALU inputs.

## Interface
- TAG_W, 4, width of the opaque tag carried from request to response
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request present
- req0_ready  out  1  port 0 request accepted this cycle (combinational)
- req0_op  in  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sra, 110 srl, 111 sll
- req0_a, req0_b  in  32 each  operands, passed unchanged to ALU a/b
- req0_tag  in  TAG_W  returned with the result
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_tag  same as port 0, for port 1
- resp_valid  out  1  output register holds a result
- resp_ready  in  1  consumer accepts the result this cycle
- resp_id  out  1  port that issued the held result
- resp_r  out  32  registered ALU result
- resp_zero  out  1  1 when resp_r == 32'h0
- resp_tag  out  TAG_W  tag of the held result

## Operation
- Two states:
  - EMPTY: output register invalid.
  - FULL: output register holds an unconsumed result.
- can_accept = (state == EMPTY) || resp_ready.
- Arbitration, evaluated every cycle:
  - If only one reqN_valid is high, that port is the candidate.
  - If both are high, the port named by the priority pointer `prio` wins.
- reqN_ready = can_accept && (N is the winner). A request transfers when reqN_valid && reqN_ready.
- On transfer:
  - ALU inputs a, b, a5 are driven from the winner's op/a/b in the same cycle.
  - The ALU result and the winner's id and tag are captured into the output register.
  - resp_zero is computed by this block as the 32-bit NOR of the ALU result. The ALU zero port is left unconnected.
  - `prio` moves to the other port (1 - winner).
- With no transfer, `prio` holds. A port holding valid alone does not change `prio`.
- State transitions:
  - EMPTY, transfer → FULL.
  - EMPTY, no transfer → EMPTY.
  - FULL, resp_ready with a transfer → FULL; the new result replaces the old one in the same edge (back-to-back).
  - FULL, resp_ready without a transfer → EMPTY.
  - FULL, !resp_ready → FULL; resp_* held stable and both reqN_ready = 0.
- When no port wins, the ALU inputs are driven to zero (op 000, a = b = 0). This keeps the ALU output quiet.
- A requester may drop valid before it is granted; no state is affected.
- The block never reorders results. There is one result in flight at most.

## Timing
- Request-to-response latency is 1 cycle: a transfer at edge N gives resp_valid = 1 after edge N.
- Throughput is 1 result per cycle when resp_ready is held high.
- reqN_ready depends combinationally on resp_ready, reqN_valid and `prio`. There is no path from reqN_op/a/b to any ready output.
- The ALU result path is combinational into the resp_r register. This is the critical path: mux → ALU → register.
- Reset values:
  - state = EMPTY, resp_valid = 0, resp_r = 0, resp_zero = 0, resp_id = 0, resp_tag = 0.
  - prio = 0, so port 0 wins the first contention.
- Reset mid-operation discards any held result. reqN_ready is 0 during the reset cycle.
- Both ports valid continuously with resp_ready = 1 gives strictly alternating grants.

## Structure
- The shared package holds:
  - the ALU opcode constants (ALU_ADD … ALU_SLL, 3 bits);
  - the state encoding (ST_EMPTY, ST_FULL);
  - the default TAG_W.
- One sub-module is natural: the existing ALU, instantiated once inside alu_arbiter. Arbitration and the output register stay in the top module.

## Test plan
- Single request, port 0: op 000, a = 5, b = 7, tag 3, resp_ready = 1 → next cycle resp_valid = 1, resp_r = 12, resp_zero = 0, resp_id = 0, resp_tag = 3.
- Zero flag, port 1: op 001, a = b = 32'h1234 → resp_r = 0, resp_zero = 1, resp_id = 1.
- Contention: both ports valid for 4 cycles, port 0 op 010 (a&b), port 1 op 011 (a|b), resp_ready = 1 → grants 0, 1, 0, 1 and results appear in that order, one per cycle.
- Backpressure: result held with resp_ready = 0 for 3 cycles while port 1 is valid → resp_* stable, req1_ready = 0. When resp_ready rises: old result consumed and port 1 accepted in the same cycle, new result next cycle.
- Back-to-back: port 0 issues op 100 (a = 32'hFF, b = 32'h0F) then op 000 (1 + 1) with resp_ready = 1 → resp_r = 32'hF0, then 2, no bubble.
- Reset mid-operation: assert rst while FULL with resp_ready = 0 → after edge resp_valid = 0, prio = 0. A subsequent dual request grants port 0 first.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: opcode encoding, output-stage
// state encoding and default widths.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned TAG_W_DEF = 4;
  localparam int unsigned SHAMT_W   = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SRA = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLL = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU.
// Ports: op (opcode), a/b (operands), r (result), zero (r == 0).
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] r,
  output logic              zero
);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    r = '0;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SRA: r = DATA_W'($signed(a) >>> shamt);
      ALU_SRL: r = a >> shamt;
      ALU_SLL: r = a << shamt;
      default: r = '0;
    endcase
  end

  assign zero = (r == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters,
// with a one-entry registered result stage that supports backpressure.
// Ports: clk, rst (sync, active high); req0_*/req1_* request ports with
// combinational ready; resp_* registered result (valid, id, r, zero, tag)
// consumed with resp_ready.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_r,
  output logic              resp_zero,
  output logic [TAG_W-1:0]  resp_tag
);

  state_e              state_q, state_d;
  logic                prio_q, prio_d;
  logic                resp_id_q, resp_id_d;
  logic [DATA_W-1:0]   resp_r_q, resp_r_d;
  logic                resp_zero_q, resp_zero_d;
  logic [TAG_W-1:0]    resp_tag_q, resp_tag_d;

  logic                can_accept;
  logic                win0, win1;
  logic                transfer;
  logic                winner;
  alu_op_e             alu_op;
  logic [DATA_W-1:0]   alu_a, alu_b, alu_r;
  logic                alu_zero_unused;

  // Arbitration: a lone valid wins outright, contention resolved by prio_q.
  // Ready never depends on operand/opcode inputs.
  always_comb begin
    can_accept = (state_q == ST_EMPTY) || resp_ready;
    win0       = req0_valid && (!req1_valid || !prio_q);
    win1       = req1_valid && (!req0_valid ||  prio_q);
    req0_ready = can_accept && win0 && !rst;
    req1_ready = can_accept && win1 && !rst;
    transfer   = req0_ready || req1_ready;
    winner     = win1;
  end

  // ALU input mux; idle inputs are zeroed to keep the ALU output quiet.
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = '0;
    alu_b  = '0;
    if (req0_ready) begin
      alu_op = alu_op_e'(req0_op);
      alu_a  = req0_a;
      alu_b  = req0_b;
    end else if (req1_ready) begin
      alu_op = alu_op_e'(req1_op);
      alu_a  = req1_a;
      alu_b  = req1_b;
    end
  end

  alu_arbiter_alu u_alu (
    .op   (alu_op),
    .a    (alu_a),
    .b    (alu_b),
    .r    (alu_r),
    .zero (alu_zero_unused)
  );

  // Next-state and output-register update.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    resp_id_d   = resp_id_q;
    resp_r_d    = resp_r_q;
    resp_zero_d = resp_zero_q;
    resp_tag_d  = resp_tag_q;

    case (state_q)
      ST_EMPTY: if (transfer) state_d = ST_FULL;
      ST_FULL:  if (resp_ready && !transfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (transfer) begin
      prio_d      = ~winner;
      resp_id_d   = winner;
      resp_r_d    = alu_r;
      resp_zero_d = ~|alu_r;
      resp_tag_d  = winner ? req1_tag : req0_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      prio_q      <= 1'b0;
      resp_id_q   <= 1'b0;
      resp_r_q    <= '0;
      resp_zero_q <= 1'b0;
      resp_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      resp_id_q   <= resp_id_d;
      resp_r_q    <= resp_r_d;
      resp_zero_q <= resp_zero_d;
      resp_tag_q  <= resp_tag_d;
    end
  end

  assign resp_valid = (state_q == ST_FULL);
  assign resp_id    = resp_id_q;
  assign resp_r     = resp_r_q;
  assign resp_zero  = resp_zero_q;
  assign resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;

  localparam int unsigned TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready;
  logic [2:0]        req0_op;
  logic [31:0]       req0_a, req0_b;
  logic [TAG_W-1:0]  req0_tag;
  logic              req1_valid, req1_ready;
  logic [2:0]        req1_op;
  logic [31:0]       req1_a, req1_b;
  logic [TAG_W-1:0]  req1_tag;
  logic              resp_valid, resp_ready, resp_id, resp_zero;
  logic [31:0]       resp_r;
  logic [TAG_W-1:0]  resp_tag;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_tag   (req1_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_r     (resp_r),
    .resp_zero  (resp_zero),
    .resp_tag   (resp_tag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_tag = t;
  endtask

  task automatic drive1(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_tag = t;
  endtask

  task automatic chk_resp(input string tag, input logic v, input logic id,
                          input logic [31:0] r, input logic z, input logic [TAG_W-1:0] t);
    chk({tag, ".valid"}, 32'(resp_valid), 32'(v));
    chk({tag, ".id"},    32'(resp_id),    32'(id));
    chk({tag, ".r"},     resp_r,          r);
    chk({tag, ".zero"},  32'(resp_zero),  32'(z));
    chk({tag, ".tag"},   32'(resp_tag),   32'(t));
  endtask

  // Single port-0 op, one cycle, expected result checked after the edge.
  task automatic one_op0(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    drive0(1'b1, op, a, b, 4'h6);
    #1;
    chk({tag, ".rdy0"}, 32'(req0_ready), 32'd1);
    tick();
    chk({tag, ".r"},    resp_r, exp);
  endtask

  logic [31:0] exp_c [4];
  logic        exp_g [4];

  initial begin
    rst = 1'b1; resp_ready = 1'b0;
    drive0(1'b1, 3'b000, 32'd1, 32'd1, 4'h0);
    drive1(1'b1, 3'b000, 32'd1, 32'd1, 4'h0);
    #1;
    chk("rst.rdy0", 32'(req0_ready), 32'd0);
    chk("rst.rdy1", 32'(req1_ready), 32'd0);
    tick(); tick();
    chk_resp("rst", 1'b0, 1'b0, 32'h0, 1'b0, 4'h0);
    drive0(1'b0, 3'b000, 32'd0, 32'd0, 4'h0);
    drive1(1'b0, 3'b000, 32'd0, 32'd0, 4'h0);
    rst = 1'b0;
    tick();
    chk("idle.valid", 32'(resp_valid), 32'd0);

    // Single request on port 0: 5 + 7.
    resp_ready = 1'b1;
    drive0(1'b1, 3'b000, 32'd5, 32'd7, 4'h3);
    #1;
    chk("single.rdy0", 32'(req0_ready), 32'd1);
    tick();
    drive0(1'b0, 3'b000, 32'd0, 32'd0, 4'h0);
    chk_resp("single", 1'b1, 1'b0, 32'd12, 1'b0, 4'h3);

    // Zero flag on port 1 (sub equal operands); taken while FULL with resp_ready.
    drive1(1'b1, 3'b001, 32'h1234, 32'h1234, 4'h5);
    #1;
    chk("zero.rdy1", 32'(req1_ready), 32'd1);
    tick();
    drive1(1'b0, 3'b000, 32'd0, 32'd0, 4'h0);
    chk_resp("zero", 1'b1, 1'b1, 32'h0, 1'b1, 4'h5);

    // Contention: AND on port 0, OR on port 1, alternating grants from port 0.
    exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
    exp_c[0] = 32'h0000_F000; exp_c[1] = 32'h0000_0FF0;
    exp_c[2] = 32'h0000_F000; exp_c[3] = 32'h0000_0FF0;
    drive0(1'b1, 3'b010, 32'h0000_F0F0, 32'h0000_FF00, 4'h1);
    drive1(1'b1, 3'b011, 32'h0000_00F0, 32'h0000_0F00, 4'h2);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont%0d.rdy0", i), 32'(req0_ready), 32'(!exp_g[i]));
      chk($sformatf("cont%0d.rdy1", i), 32'(req1_ready), 32'(exp_g[i]));
      tick();
      chk_resp($sformatf("cont%0d", i), 1'b1, exp_g[i], exp_c[i], 1'b0,
               exp_g[i] ? 4'h2 : 4'h1);
    end
    drive0(1'b0, 3'b000, 32'd0, 32'd0, 4'h0);
    drive1(1'b0, 3'b000, 32'd0, 32'd0, 4'h0);
    tick();
    chk("drain.valid", 32'(resp_valid), 32'd0);

    // Backpressure: hold 10+20 while port 1 waits with 1+2.
    drive0(1'b1, 3'b000, 32'd10, 32'd20, 4'h7);
    tick();
    drive0(1'b0, 3'b000, 32'd0, 32'd0, 4'h0);
    resp_ready = 1'b0;
    drive1(1'b1, 3'b000, 32'd1, 32'd2, 4'h9);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d.rdy1", i), 32'(req1_ready), 32'd0);
      tick();
      chk_resp($sformatf("bp%0d", i), 1'b1, 1'b0, 32'd30, 1'b0, 4'h7);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp.release.rdy1", 32'(req1_ready), 32'd1);
    tick();
    drive1(1'b0, 3'b000, 32'd0, 32'd0, 4'h0);
    chk_resp("bp.new", 1'b1, 1'b1, 32'd3, 1'b0, 4'h9);
    tick();
    chk("bp.drain.valid", 32'(resp_valid), 32'd0);

    // Back-to-back port 0 plus remaining opcodes, no bubbles.
    one_op0("b2b.xor", 3'b100, 32'hFF, 32'h0F, 32'hF0);
    one_op0("b2b.add", 3'b000, 32'd1, 32'd1, 32'd2);
    one_op0("sub.neg", 3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE);
    one_op0("sra",     3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000);
    one_op0("srl",     3'b110, 32'h8000_0000, 32'd4, 32'h0800_0000);
    one_op0("sll",     3'b111, 32'd1, 32'd31, 32'h8000_0000);
    chk("b2b.valid", 32'(resp_valid), 32'd1);

    // Reset while FULL and stalled; prio must return to port 0.
    resp_ready = 1'b0;
    drive0(1'b0, 3'b000, 32'd0, 32'd0, 4'h0);
    tick();
    rst = 1'b1;
    drive0(1'b1, 3'b000, 32'd2, 32'd2, 4'hA);
    drive1(1'b1, 3'b000, 32'd3, 32'd3, 4'hB);
    #1;
    chk("mrst.rdy0", 32'(req0_ready), 32'd0);
    chk("mrst.rdy1", 32'(req1_ready), 32'd0);
    tick();
    rst = 1'b0;
    chk_resp("mrst", 1'b0, 1'b0, 32'h0, 1'b0, 4'h0);
    resp_ready = 1'b1;
    #1;
    chk("mrst.grant.rdy0", 32'(req0_ready), 32'd1);
    chk("mrst.grant.rdy1", 32'(req1_ready), 32'd0);
    tick();
    chk_resp("mrst.first", 1'b1, 1'b0, 32'd4, 1'b0, 4'hA);
    #1;
    chk("mrst.next.rdy1", 32'(req1_ready), 32'd1);
    tick();
    chk_resp("mrst.second", 1'b1, 1'b1, 32'd6, 1'b0, 4'hB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
